ps2_keyboard_receiver: RTL and testbench
========================================

# ps2_keyboard_receiver

Front end of the keyboard path. Samples the open-collector PS/2 clock and data lines from the keyboard, deserializes 11-bit device-to-host frames, and checks parity and framing. Decodes the 0xE0 (extended) and 0xF0 (break) prefixes into a held scan code plus one-cycle make and release strobes. The display controller and strobe logic downstream consume `KeyPress` and `KeyRelease` directly.

## Interface
- `FILTER_LEN`, 8: consecutive `clk` cycles `ps2_clk` must hold a new level before the filtered clock changes.
- `TIMEOUT_CYCLES`, 200000: idle `clk` cycles inside a frame before it is abandoned (2 ms at 100 MHz).

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `KeyPress` out 8: last decoded scan code; held until the next code.
- `KeyMake` out 1: one-cycle pulse when a make code lands in `KeyPress`.
- `KeyRelease` out 1: one-cycle pulse when a break code lands in `KeyPress`.
- `Extended` out 1: 1 if the last code was 0xE0-prefixed; updates with `KeyPress`.
- `FrameErr` out 1: one-cycle pulse on parity, stop-bit or timeout failure.

## Operation
- **Line conditioning**
  - Both lines go through 2-flop synchronizers. Reset value of the synchronizers is 1.
  - The synchronized `ps2_clk` feeds a stability filter. The filtered level changes only after `FILTER_LEN` equal samples. Reset value is 1.
  - `fall` is a one-cycle strobe, registered, on a filtered 1→0 transition.
  - Data is sampled from the synchronized `ps2_data` on the cycle `fall` is high.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP)
  - IDLE: `fall` with data=0 → DATA, clear bit counter. `fall` with data=1 is ignored.
  - DATA: each `fall` shifts the data bit in, LSB first (shift right, new bit into bit 7). The 8th bit → PARITY.
  - PARITY: the `fall` captures the parity bit → STOP.
  - STOP: the `fall` checks the frame. If data=1 and the 9 bits (data plus parity) have an odd number of ones, assert internal `byte_rdy` with the byte. Otherwise pulse `FrameErr`. Either way → IDLE.
  - Timeout counter: zero in IDLE; cleared on every `fall`; increments otherwise. On reaching `TIMEOUT_CYCLES`: pulse `FrameErr` → IDLE.
- **Code decoder**: pending flags `ext_pend` and `brk_pend`, applied on each `byte_rdy`.
  - 0xE0 → set `ext_pend`.
  - 0xF0 → set `brk_pend`.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF with no prefix pending → dropped, no output change.
  - Any other byte with `brk_pend` set → load `KeyPress`, set `Extended` = `ext_pend`, pulse `KeyRelease`, clear both flags.
  - Any other byte otherwise → load `KeyPress`, set `Extended` = `ext_pend`, pulse `KeyMake`, clear `ext_pend`.
  - `FrameErr` clears both pending flags.
- **Reset**: all outputs are 0 (`KeyPress` = 8'h00). FSM is in IDLE; counters and pending flags are cleared. Reset mid-frame discards the partial frame immediately.

## Timing
- Raw `ps2_clk` fall to `fall` strobe: 2 sync cycles + `FILTER_LEN` + 1 register cycle.
- Stop-bit `fall` at cycle N → `byte_rdy` at N+1 → `KeyPress`/`Extended`/strobes visible at N+2.
- `KeyMake` and `KeyRelease` are never high together and never wider than one cycle.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.
- Data is stable at the sample point because the device changes data only while the clock is high. The low phase (≥30 µs) far exceeds the filter delay.
- Timeout and `fall` in the same cycle: `fall` wins, and the counter clears.

## Structure
- Shared package `ps2_pkg` holds:
  - constants `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0;
  - the dropped-code list;
  - the frame-state enum.
- One sub-module, `ps2_line_filter`: synchronizers, stability filter and `fall` generation. The frame FSM and code decoder stay in the top.

## Test plan
- Frame 0x1C, parity 0, stop 1 → `KeyMake` pulses once; `KeyPress` = 0x1C; `Extended` = 0; `FrameErr` stays 0.
- Frames 0xF0 then 0x1C → single `KeyRelease` pulse; `KeyPress` = 0x1C; no `KeyMake` on either byte.
- Frames 0xE0, 0xF0, 0x75 → `KeyRelease` pulse with `KeyPress` = 0x75 and `Extended` = 1. A following plain 0x29 gives `KeyMake` with `Extended` = 0.
- Frame 0x1C with parity 1, then stop 0 on a second frame → two `FrameErr` pulses; `KeyPress` unchanged. A prior 0xF0 pending is cleared, so the next 0x1C produces `KeyMake`.
- Start bit + 3 data bits, then the clock stops → `FrameErr` after `TIMEOUT_CYCLES`. The next clean 0x29 frame decodes correctly. A 3-cycle low glitch on `ps2_clk` produces no bit.
- `rst` asserted after 5 data bits → outputs 0 immediately; the next full 0x1C frame decodes as `KeyMake`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, dropped-code list and frame-state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int NUM_DROPPED = 6;
   // Keyboard status/ack bytes that carry no key information unless a prefix is pending.
   localparam logic [7:0] DROPPED_CODES [NUM_DROPPED] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } frame_state_t;

   function automatic logic is_dropped(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_DROPPED; i++) begin
         if (code == DROPPED_CODES[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, debounces the clock and emits a registered strobe on
// each filtered falling edge of ps2_clk.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          filt;
   logic [CW-1:0] cnt;
   logic          flip;

   // The filtered level flips once FILTER_LEN consecutive samples disagree with it.
   assign flip = (clk_sync[1] != filt) && (cnt == CW'(FILTER_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         filt      <= 1'b1;
         cnt       <= '0;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         fall      <= flip && filt;
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (flip) begin
            filt <= clk_sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign data = data_sync[1];

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding into a held scan code
// and single-cycle make/release/error strobes.
module ps2_keyboard_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] KeyPress,
   output logic       KeyMake,
   output logic       KeyRelease,
   output logic       Extended,
   output logic       FrameErr
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          data;
   frame_state_t  state;
   frame_state_t  state_next;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          parity_bit;
   logic [TW-1:0] tcnt;
   logic          timeout_hit;
   logic          byte_done;
   logic          frame_bad;
   logic          byte_rdy;
   logic          err_q;
   logic [7:0]    rx_byte;
   logic          ext_pend;
   logic          brk_pend;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall),
      .data     (data)
   );

   // A fall in the same cycle always wins over the timeout.
   assign timeout_hit = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (timeout_hit) begin
         state_next = S_IDLE;
      end else if (fall) begin
         case (state)
            S_IDLE:   if (!data) state_next = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
            S_PARITY: state_next = S_STOP;
            S_STOP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      byte_done = 1'b0;
      frame_bad = timeout_hit;
      if (state == S_STOP && fall) begin
         if (data && (^{shift, parity_bit})) byte_done = 1'b1;
         else                                frame_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift      <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         tcnt       <= '0;
         byte_rdy   <= 1'b0;
         err_q      <= 1'b0;
         rx_byte    <= '0;
      end else begin
         byte_rdy <= byte_done;
         err_q    <= frame_bad;
         if (byte_done) rx_byte <= shift;
         if (state == S_IDLE || fall) tcnt <= '0;
         else                         tcnt <= tcnt + TW'(1);
         if (fall) begin
            case (state)
               S_IDLE:   bit_cnt <= '0;
               S_DATA: begin
                  shift   <= {data, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               S_PARITY: parity_bit <= data;
               default:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         KeyPress   <= '0;
         KeyMake    <= 1'b0;
         KeyRelease <= 1'b0;
         Extended   <= 1'b0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
      end else begin
         KeyMake    <= 1'b0;
         KeyRelease <= 1'b0;
         if (err_q) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (byte_rdy) begin
            if (rx_byte == PS2_EXT) begin
               ext_pend <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
               brk_pend <= 1'b1;
            end else if (!(is_dropped(rx_byte) && !ext_pend && !brk_pend)) begin
               KeyPress <= rx_byte;
               Extended <= ext_pend;
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
               if (brk_pend) KeyRelease <= 1'b1;
               else          KeyMake    <= 1'b1;
            end
         end
      end
   end

   assign FrameErr = err_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: frame driver, event scoreboard and
// a reference model of the key-code decoding rules.
module tb_ps2_keyboard_receiver;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 2000;
   localparam int HALF           = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] KeyPress;
   logic       KeyMake;
   logic       KeyRelease;
   logic       Extended;
   logic       FrameErr;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Event encoding: {kind[1:0], Extended, KeyPress}; kind 1=make, 2=release, 3=frame error.
   logic [10:0] exp_q[$];

   logic [7:0] m_key;
   logic       m_ext;
   logic       m_epend;
   logic       m_bpend;

   always #5 clk = ~clk;

   ps2_keyboard_receiver #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .KeyPress   (KeyPress),
      .KeyMake    (KeyMake),
      .KeyRelease (KeyRelease),
      .Extended   (Extended),
      .FrameErr   (FrameErr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic bit is_status(input logic [7:0] b);
      return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
   endfunction

   task automatic model_reset();
      m_key = 8'h00; m_ext = 1'b0; m_epend = 1'b0; m_bpend = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_epend = 1'b1;
      else if (b == 8'hF0) m_bpend = 1'b1;
      else if (!(is_status(b) && !m_epend && !m_bpend)) begin
         m_key = b;
         m_ext = m_epend;
         exp_q.push_back({(m_bpend ? 2'd2 : 2'd1), m_ext, m_key});
         m_epend = 1'b0;
         m_bpend = 1'b0;
      end
   endtask

   task automatic model_err();
      exp_q.push_back({2'd3, m_ext, m_key});
      m_epend = 1'b0;
      m_bpend = 1'b0;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Data changes only while the clock is high, as a real keyboard does.
   task automatic ps2_bit(input logic v);
      ps2_data = v;
      wait_neg(HALF / 2);
      ps2_clk = 1'b0;
      wait_neg(HALF);
      ps2_clk = 1'b1;
      wait_neg(HALF / 2);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_val, input bit glitch);
      logic par;
      par = ~(^b) ^ par_bad;
      if (par_bad || !stop_val) model_err();
      else model_byte(b);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         ps2_bit(b[i]);
         if (glitch && i == 0) begin
            ps2_clk = 1'b0;
            wait_neg(3);
            ps2_clk = 1'b1;
            wait_neg(HALF / 2);
         end
      end
      ps2_bit(par);
      ps2_bit(stop_val);
      ps2_data = 1'b1;
      wait_neg(2 * HALF);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      wait_neg(20);
      check(name, exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && (KeyMake || KeyRelease || FrameErr)) begin
         check("one_strobe", 32'(KeyMake) + 32'(KeyRelease) + 32'(FrameErr), 1);
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got %0h expected none",
                     {(FrameErr ? 2'd3 : (KeyRelease ? 2'd2 : 2'd1)), Extended, KeyPress});
         end else begin
            check("event", {(FrameErr ? 2'd3 : (KeyRelease ? 2'd2 : 2'd1)), Extended, KeyPress},
                  exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [7:0] b;
      int sel;
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      model_reset();
      wait_neg(5);
      check("reset_outputs", {KeyPress, KeyMake, KeyRelease, Extended, FrameErr}, 0);
      rst = 1'b0;
      wait_neg(20);

      send_frame(8'h1C, 0, 1, 0);
      drain("plain_make");
      check("make_key", KeyPress, 8'h1C);

      send_frame(8'hF0, 0, 1, 0);
      send_frame(8'h1C, 0, 1, 0);
      drain("break_release");

      send_frame(8'hE0, 0, 1, 0);
      send_frame(8'hF0, 0, 1, 0);
      send_frame(8'h75, 0, 1, 0);
      send_frame(8'h29, 0, 1, 0);
      drain("ext_release");
      check("ext_cleared", Extended, 0);

      send_frame(8'hF0, 0, 1, 0);
      send_frame(8'h1C, 1, 1, 0);
      send_frame(8'h1C, 0, 0, 0);
      send_frame(8'h1C, 0, 1, 0);
      drain("frame_errors");

      // Start bit and three data bits, then the keyboard goes quiet.
      model_err();
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      ps2_data = 1'b1;
      wait_neg(TIMEOUT_CYCLES + 200);
      drain("timeout");
      send_frame(8'h29, 0, 1, 1);
      drain("after_timeout_glitch");

      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
      rst = 1'b1;
      wait_neg(2);
      check("rst_keypress", KeyPress, 0);
      check("rst_strobes", {KeyMake, KeyRelease, Extended, FrameErr}, 0);
      model_reset();
      ps2_data = 1'b1;
      wait_neg(5);
      rst = 1'b0;
      wait_neg(20);
      send_frame(8'h1C, 0, 1, 0);
      drain("after_reset");

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         b = 8'($urandom_range(0, 255));
         case (sel)
            0: send_frame(8'hE0, 0, 1, 0);
            1: send_frame(8'hF0, 0, 1, 0);
            2: begin
               case ($urandom_range(0, 5))
                  0: b = 8'hAA;
                  1: b = 8'hFA;
                  2: b = 8'hEE;
                  3: b = 8'hFE;
                  4: b = 8'h00;
                  default: b = 8'hFF;
               endcase
               send_frame(b, 0, 1, 0);
            end
            3: send_frame(b, 1, 1, 0);
            4: send_frame(b, 0, 0, 0);
            default: send_frame(b, 0, 1, 0);
         endcase
      end
      drain("random");
      check("final_key", {Extended, KeyPress}, {m_ext, m_key});

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
